dm_lane_pipe: RTL and testbench

//  Parametrised successor to the single-cycle data memory of the pipelined MIPS core.
//  - Adds byte/half/word stores via byte lanes, and sign/zero-extended loads (lb/lbu/lh/lhu/lw).
//  - Adds a configurable read-latency pipeline with a valid/ready handshake.
//  - Detects misaligned and out-of-range accesses.
//  - Sits in the MEM stage; every accepted request returns exactly one in-order response.

---
 rtl/dm_lane_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_dm_lane_pipe.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_lane_pipe.sv
// dm_lane_pipe: MEM-stage data memory with byte-lane stores, sign/zero
// extended loads, a READ_LAT-deep response pipeline with valid/ready
// handshake, and exception flagging for misaligned, out-of-range and
// illegal-size requests. Every accepted request yields exactly one
// response, returned in accept order.
module dm_lane_pipe #(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          READ_LAT    = 1,
  parameter bit          LOG_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_exc,
  output logic        busy
);

  // READ_LAT is expected in the range 1..4; the last stage drives rsp_*.
  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;
  localparam int          LAST       = READ_LAT - 1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      off;
  logic             in_range;
  logic             misaligned;
  logic             req_exc;
  logic [IDX_W-1:0] idx;
  logic [31:0]      cur_word;
  logic [31:0]      new_word;
  logic [31:0]      lane_data;
  logic [3:0]       lane_en;
  logic             stall;
  logic             accept;
  logic             commit;
  logic             load_ok;

  logic [READ_LAT-1:0] st_valid;
  logic [31:0]         st_word [READ_LAT];
  logic [1:0]          st_lane [READ_LAT];
  logic [1:0]          st_size [READ_LAT];
  logic                st_uns  [READ_LAT];
  logic                st_exc  [READ_LAT];
  logic                st_load [READ_LAT];

  logic [31:0] last_word;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ext_data;

  // Decode the request: offset, range/alignment checks, word index and current word.
  always_comb begin
    off        = req_addr - BASE_ADDR;
    in_range   = off < SPAN_BYTES;
    misaligned = 1'b0;
    case (req_size)
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    req_exc  = !in_range || (req_size == SZ_BAD) || misaligned;
    idx      = off[IDX_W+1:2];
    cur_word = in_range ? mem[idx] : 32'h0;
  end

  // Build the byte-lane enables and replicated store data, then merge into the current word.
  always_comb begin
    lane_en   = 4'b0000;
    lane_data = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        lane_en   = 4'b0001 << req_addr[1:0];
        lane_data = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        lane_en   = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        lane_en   = 4'b1111;
        lane_data = req_wdata;
      end
      default: begin
        lane_en   = 4'b0000;
        lane_data = req_wdata;
      end
    endcase
    new_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (lane_en[b]) begin
        new_word[b*8 +: 8] = lane_data[b*8 +: 8];
      end
    end
  end

  // Handshake: a response waiting on a busy consumer freezes the whole pipe.
  always_comb begin
    stall     = rsp_valid && !rsp_ready;
    req_ready = !stall;
    accept    = req_valid && req_ready;
    commit    = accept && req_we && !req_exc;
    load_ok   = accept && !req_we && !req_exc;
  end

  // Storage array: cleared on reset, written with the merged word on a committed store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[IDX_W'(i)] <= 32'h0;
      end
    end else if (commit) begin
      mem[idx] <= new_word;
    end
  end

  // Response pipeline: stage 0 captures the accepted request, later stages shift when not stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_valid <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        st_word[i] <= 32'h0;
        st_lane[i] <= 2'b00;
        st_size[i] <= 2'b00;
        st_uns[i]  <= 1'b0;
        st_exc[i]  <= 1'b0;
        st_load[i] <= 1'b0;
      end
    end else if (!stall) begin
      st_valid[0] <= accept;
      st_word[0]  <= load_ok ? cur_word : 32'h0;
      st_lane[0]  <= req_addr[1:0];
      st_size[0]  <= req_size;
      st_uns[0]   <= req_unsigned;
      st_exc[0]   <= accept && req_exc;
      st_load[0]  <= load_ok;
      for (int i = 1; i < READ_LAT; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_word[i]  <= st_word[i-1];
        st_lane[i]  <= st_lane[i-1];
        st_size[i]  <= st_size[i-1];
        st_uns[i]   <= st_uns[i-1];
        st_exc[i]   <= st_exc[i-1];
        st_load[i]  <= st_load[i-1];
      end
    end
  end

  // Last stage: pick the addressed byte/half and sign- or zero-extend it.
  always_comb begin
    last_word = st_word[LAST];
    case (st_lane[LAST])
      2'd0:    sel_byte = last_word[7:0];
      2'd1:    sel_byte = last_word[15:8];
      2'd2:    sel_byte = last_word[23:16];
      default: sel_byte = last_word[31:24];
    endcase
    sel_half = st_lane[LAST][1] ? last_word[31:16] : last_word[15:0];
    case (st_size[LAST])
      SZ_BYTE: ext_data = {{24{!st_uns[LAST] && sel_byte[7]}}, sel_byte};
      SZ_HALF: ext_data = {{16{!st_uns[LAST] && sel_half[15]}}, sel_half};
      default: ext_data = last_word;
    endcase
  end

  // Drive the response port; data is forced to zero for stores, exceptions and idle cycles.
  always_comb begin
    rsp_valid = st_valid[LAST];
    rsp_rdata = (st_valid[LAST] && st_load[LAST]) ? ext_data : 32'h0;
    rsp_exc   = st_valid[LAST] && st_exc[LAST];
    busy      = |st_valid;
  end

`ifndef SYNTHESIS
  // Simulation trace of every committed store with the full merged word.
  generate
    if (LOG_EN) begin : g_log
      always @(posedge clk) begin
        if (reset && commit) begin
          $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, new_word);
        end
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_dm_lane_pipe.sv
// tb_dm_lane_pipe: directed and randomized checks of dm_lane_pipe at
// READ_LAT 1, 2 and 3 against a byte-addressed reference memory.
module tb_dm_lane_pipe;

  localparam int N_DUT     = 3;
  localparam int MEM_BYTES = 3072 * 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        exc;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;

  logic        req_valid    [N_DUT];
  logic        req_ready    [N_DUT];
  logic        req_we       [N_DUT];
  logic [1:0]  req_size     [N_DUT];
  logic        req_unsigned [N_DUT];
  logic [31:0] req_addr     [N_DUT];
  logic [31:0] req_wdata    [N_DUT];
  logic [31:0] req_pc       [N_DUT];
  logic        rsp_valid    [N_DUT];
  logic        rsp_ready    [N_DUT];
  logic [31:0] rsp_rdata    [N_DUT];
  logic        rsp_exc      [N_DUT];
  logic        busy         [N_DUT];

  logic [7:0] model_mem [N_DUT][MEM_BYTES];
  rsp_t       exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  int cyc      = 0;
  int cur      = 0;
  bit last_accepted = 1'b0;
  bit rand_ready    = 1'b0;

  // Free-running clock.
  always #5 clk = ~clk;

  // One DUT per latency: instance g has READ_LAT = g+1.
  generate
    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      dm_lane_pipe #(
        .DEPTH_WORDS(3072),
        .BASE_ADDR  (32'h0000_0000),
        .READ_LAT   (g + 1),
        .LOG_EN     (1'b1)
      ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid[g]),
        .req_ready   (req_ready[g]),
        .req_we      (req_we[g]),
        .req_size    (req_size[g]),
        .req_unsigned(req_unsigned[g]),
        .req_addr    (req_addr[g]),
        .req_wdata   (req_wdata[g]),
        .req_pc      (req_pc[g]),
        .rsp_valid   (rsp_valid[g]),
        .rsp_ready   (rsp_ready[g]),
        .rsp_rdata   (rsp_rdata[g]),
        .rsp_exc     (rsp_exc[g]),
        .busy        (busy[g])
      );
    end
  endgenerate

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference model: byte-addressed little-endian memory, extension by arithmetic.
  task automatic model_accept(input int k, input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata, output rsp_t r);
    int     nb;
    longint val;
    longint half;
    r.rdata = 32'h0;
    r.exc   = 1'b0;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (size == 2'd3 || addr >= 32'(MEM_BYTES) || (addr % 32'(nb)) != 32'h0) begin
      r.exc = 1'b1;
    end else if (we) begin
      for (int i = 0; i < nb; i++) model_mem[k][int'(addr) + i] = wdata[8*i +: 8];
    end else begin
      val = 0;
      for (int i = 0; i < nb; i++) val += longint'(model_mem[k][int'(addr) + i]) << (8 * i);
      half = longint'(1) << (8 * nb - 1);
      if (!uns && nb < 4 && val >= half) val -= (half << 1);
      r.rdata = 32'(val);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < N_DUT; k++)
      for (int a = 0; a < MEM_BYTES; a++) model_mem[k][a] = 8'h00;
  endtask

  // One clock: sample handshakes just before the edge, then move to the next falling edge.
  task automatic tick();
    rsp_t e;
    rsp_t r;
    if (rand_ready) rsp_ready[cur] = ($urandom % 4) != 0;
    #1;
    last_accepted = 1'b0;
    if (rsp_valid[cur] && rsp_ready[cur]) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("[TB] FAIL spurious_rsp: observed response %h, expected none", rsp_rdata[cur]);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output("rsp_rdata", rsp_rdata[cur], e.rdata);
        check_output("rsp_exc", 32'(rsp_exc[cur]), 32'(e.exc));
        n_rsp++;
      end
    end
    if (req_valid[cur] && req_ready[cur]) begin
      model_accept(cur, req_we[cur], req_size[cur], req_unsigned[cur], req_addr[cur], req_wdata[cur], r);
      exp_q.push_back(r);
      last_accepted = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[cur]    = 1'b1;
    req_we[cur]       = we;
    req_size[cur]     = size;
    req_unsigned[cur] = uns;
    req_addr[cur]     = addr;
    req_wdata[cur]    = wdata;
    req_pc[cur]       = 32'h0040_0000 + 32'(cyc) * 4;
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!last_accepted && n < 40);
    req_valid[cur] = 1'b0;
    n_assert++;
    assert (last_accepted) else begin
      n_fail++;
      $error("[TB] FAIL %s: accept observed 0 within %0d cycles, expected 1", tag, n);
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
    set_req(we, size, uns, addr, wdata);
    wait_accept(tag);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d responses outstanding, expected 0", tag, exp_q.size());
    end
  endtask

  // Directed sequence followed by a randomized phase.
  initial begin
    int   rsp_before;
    int   s;
    logic [31:0] a;

    reset = 1'b0;
    for (int k = 0; k < N_DUT; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = 2'd0; req_unsigned[k] = 1'b0;
      req_addr[k] = 32'h0; req_wdata[k] = 32'h0; req_pc[k] = 32'h0; rsp_ready[k] = 1'b1;
    end
    clear_model();
    repeat (3) @(negedge clk);
    check_output("rst_rsp_valid", 32'(rsp_valid[0]), 32'h0);
    check_output("rst_busy", 32'(busy[0]), 32'h0);
    reset = 1'b1;
    #1;
    for (int k = 0; k < N_DUT; k++) begin
      check_output("rst_req_ready", 32'(req_ready[k]), 32'h1);
      check_output("rst_rsp_rdata", rsp_rdata[k], 32'h0);
      check_output("rst_rsp_exc", 32'(rsp_exc[k]), 32'h0);
    end

    // Test 1: sw then lw, single-cycle latency.
    cur = 0;
    apply_stimulus("t1_sw", 1'b1, 2'd2, 1'b0, 32'h0, 32'h8765_4321);
    apply_stimulus("t1_lw", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    check_output("t1_lat_valid", 32'(rsp_valid[0]), 32'h1);
    check_output("t1_lat_rdata", rsp_rdata[0], 32'h8765_4321);
    drain("t1_drain");

    // Test 2: byte store then signed/unsigned byte loads and word readback.
    apply_stimulus("t2_sb", 1'b1, 2'd0, 1'b0, 32'h2, 32'h0000_00AB);
    apply_stimulus("t2_lb", 1'b0, 2'd0, 1'b0, 32'h2, 32'h0);
    apply_stimulus("t2_lbu", 1'b0, 2'd0, 1'b1, 32'h2, 32'h0);
    apply_stimulus("t2_lw", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    apply_stimulus("t2_lh", 1'b0, 2'd1, 1'b0, 32'h2, 32'h0);
    apply_stimulus("t2_lhu", 1'b0, 2'd1, 1'b1, 32'h2, 32'h0);
    drain("t2_drain");

    // Test 3: exceptions leave memory untouched.
    apply_stimulus("t3_sh_mis", 1'b1, 2'd1, 1'b0, 32'h1, 32'h0000_1234);
    apply_stimulus("t3_lw_oor", 1'b0, 2'd2, 1'b0, 32'h3000, 32'h0);
    apply_stimulus("t3_size3", 1'b0, 2'd3, 1'b0, 32'h4, 32'h0);
    apply_stimulus("t3_sw_mis", 1'b1, 2'd2, 1'b0, 32'h2, 32'hDEAD_BEEF);
    apply_stimulus("t3_sw_oor", 1'b1, 2'd2, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF);
    apply_stimulus("t3_lw_last", 1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0);
    apply_stimulus("t3_lw_chk", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    drain("t3_drain");

    // Test 5: load accepted the edge after a store sees the store.
    apply_stimulus("t5_sw", 1'b1, 2'd2, 1'b0, 32'h8, 32'h5555_5555);
    apply_stimulus("t5_lw", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    drain("t5_drain");

    // Test 4: READ_LAT=3, back-to-back loads with a two-cycle stall on the first response.
    cur = 2;
    for (int i = 0; i < 4; i++)
      apply_stimulus("t4_sw", 1'b1, 2'd2, 1'b0, 32'h10 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
    drain("t4_fill");
    rsp_before = n_rsp;
    apply_stimulus("t4_lw0", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check_output("t4_lat1", 32'(rsp_valid[2]), 32'h0);
    apply_stimulus("t4_lw1", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    check_output("t4_lat2", 32'(rsp_valid[2]), 32'h0);
    apply_stimulus("t4_lw2", 1'b0, 2'd2, 1'b0, 32'h18, 32'h0);
    check_output("t4_lat3", 32'(rsp_valid[2]), 32'h1);
    set_req(1'b0, 2'd2, 1'b0, 32'h1C, 32'h0);
    rsp_ready[2] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_output("t4_stall_ready", 32'(req_ready[2]), 32'h0);
      check_output("t4_stall_hold", rsp_rdata[2], 32'hC0DE_0000);
      tick();
    end
    rsp_ready[2] = 1'b1;
    wait_accept("t4_lw3");
    drain("t4_drain");
    check_output("t4_count", 32'(n_rsp - rsp_before), 32'h4);
    #1;
    check_output("t4_idle", 32'(busy[2]), 32'h0);

    // Test 6: reset with two loads in flight at READ_LAT=2.
    cur = 1;
    apply_stimulus("t6_sw", 1'b1, 2'd2, 1'b0, 32'h0, 32'h1234_5678);
    drain("t6_fill");
    apply_stimulus("t6_lw0", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    apply_stimulus("t6_lw1", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    check_output("t6_busy_pre", 32'(busy[1]), 32'h1);
    reset = 1'b0;
    #1;
    check_output("t6_rsp_valid", 32'(rsp_valid[1]), 32'h0);
    check_output("t6_busy", 32'(busy[1]), 32'h0);
    exp_q.delete();
    clear_model();
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus("t6_lw_after", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    check_output("t6_no_early", 32'(rsp_valid[1]), 32'h0);
    drain("t6_drain");
    cur = 0;
    apply_stimulus("t6_lw_dut0", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    drain("t6_drain0");

    // Randomized mix with random backpressure on the READ_LAT=3 instance.
    cur = 2;
    rand_ready = 1'b1;
    for (int n = 0; n < 80; n++) begin
      if ($urandom % 4 == 0) begin
        tick();
      end else begin
        a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom % 10 == 0) a = ($urandom % 2 == 0) ? 32'h0000_3000 + a : 32'hFFFF_FFFC;
        s = $urandom_range(0, 9);
        apply_stimulus("rnd", 1'($urandom % 2), (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3,
                       1'($urandom % 2), a, $urandom);
      end
    end
    rand_ready = 1'b0;
    rsp_ready[2] = 1'b1;
    drain("rnd_drain");
    for (int i = 0; i < 16; i++) apply_stimulus("rnd_sweep", 1'b0, 2'd2, 1'b0, 32'(4 * i), 32'h0);
    drain("rnd_sweep_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
